pipe_hazard_ctrl: RTL

Pipeline control block for the five-stage (F/D/E/M/W) successor of the single-cycle core. It tracks per-stage scoreboard records for E, M and W, and generates stall, flush and operand-forwarding selects. It supports a multi-cycle data-memory ready handshake and saturating stall and flush performance counters. It sits beside the datapath pipeline registers and drives their enable and clear inputs.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the five-stage pipeline hazard controller.
package pipe_pkg;

  // Execute operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Control half of a stage record. Register addresses live beside the
  // record so the struct does not depend on the address-width parameter.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic is_load;
    logic mem_op;
  } stage_rec_t;

  // One pipeline action per cycle, listed from highest to lowest priority.
  typedef enum logic [1:0] {
    ACT_MEM_HOLD   = 2'd0,
    ACT_TAKEN      = 2'd1,
    ACT_DATA_STALL = 2'd2,
    ACT_ADVANCE    = 2'd3
  } action_t;

  function automatic action_t pick_action(input logic mem_hold,
                                          input logic taken,
                                          input logic data_stall);
    if (mem_hold)        return ACT_MEM_HOLD;
    else if (taken)      return ACT_TAKEN;
    else if (data_stall) return ACT_DATA_STALL;
    else                 return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != CNT_MAX))
      count <= count + CNT_ONE;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: tracks E/M/W records and
// produces stall, flush and forwarding selects plus performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAD    = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  logic [WAD-1:0]   d_rs1,
  input  logic [WAD-1:0]   d_rs2,
  input  logic             d_uses_rs1,
  input  logic             d_uses_rs2,
  input  logic [WAD-1:0]   d_rd,
  input  logic             d_regwrite,
  input  logic             d_is_load,
  input  logic             d_mem_op,
  input  logic             e_pcsrc_taken,
  input  logic             m_dm_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             w_regwrite,
  output logic [WAD-1:0]   w_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // W only needs what the register file consumes; M keeps mem_op for the
  // ready handshake. Load/memory flags are not needed past those points.
  stage_rec_t     e_q;
  logic [WAD-1:0] e_rs1_q, e_rs2_q, e_rd_q;
  logic           m_valid_q, m_regwrite_q, m_mem_op_q;
  logic [WAD-1:0] m_rd_q;
  logic           w_valid_q, w_regwrite_q;
  logic [WAD-1:0] w_rd_q;

  logic    e_wr, m_wr, w_wr;
  logic    raw_e, raw_m, mem_hold, taken, data_stall;
  action_t act;

  function automatic fwd_sel_t fwd_pick(input logic [WAD-1:0] rs,
                                        input logic m_w, input logic [WAD-1:0] m_r,
                                        input logic w_w, input logic [WAD-1:0] w_r);
    if (m_w && (m_r == rs))      return FWD_M;
    else if (w_w && (w_r == rs)) return FWD_W;
    else                         return FWD_RF;
  endfunction

  // A record only produces a hazard when it really writes a non-zero rd.
  assign e_wr = e_q.valid & e_q.regwrite & (e_rd_q != '0);
  assign m_wr = m_valid_q & m_regwrite_q & (m_rd_q != '0);
  assign w_wr = w_valid_q & w_regwrite_q & (w_rd_q != '0);

  assign raw_e = d_valid & e_wr & ((d_uses_rs1 & (d_rs1 == e_rd_q)) |
                                   (d_uses_rs2 & (d_rs2 == e_rd_q)));
  assign raw_m = d_valid & m_wr & ((d_uses_rs1 & (d_rs1 == m_rd_q)) |
                                   (d_uses_rs2 & (d_rs2 == m_rd_q)));

  assign mem_hold   = m_valid_q & m_mem_op_q & ~m_dm_ready;
  assign taken      = e_q.valid & e_pcsrc_taken;
  assign data_stall = FWD_EN ? (raw_e & e_q.is_load) : (raw_e | raw_m);
  assign act        = pick_action(mem_hold, taken, data_stall);

  assign w_regwrite = w_valid_q & w_regwrite_q;
  assign w_rd       = w_rd_q;

  // Decode the selected action into pipeline-register enables and clears.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    unique case (act)
      ACT_MEM_HOLD: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end
      ACT_TAKEN: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      ACT_DATA_STALL: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand bypass selects; M is younger than W so it wins.
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (FWD_EN) begin
      fwd_a_e = fwd_pick(e_rs1_q, m_wr, m_rd_q, w_wr, w_rd_q);
      fwd_b_e = fwd_pick(e_rs2_q, m_wr, m_rd_q, w_wr, w_rd_q);
    end
  end

  // Advance, hold or bubble the E/M/W records according to the action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q          <= '0;
      e_rs1_q      <= '0;
      e_rs2_q      <= '0;
      e_rd_q       <= '0;
      m_valid_q    <= 1'b0;
      m_regwrite_q <= 1'b0;
      m_mem_op_q   <= 1'b0;
      m_rd_q       <= '0;
      w_valid_q    <= 1'b0;
      w_regwrite_q <= 1'b0;
      w_rd_q       <= '0;
    end else if (act == ACT_MEM_HOLD) begin
      w_valid_q    <= 1'b0;
      w_regwrite_q <= 1'b0;
      w_rd_q       <= '0;
    end else begin
      m_valid_q    <= e_q.valid;
      m_regwrite_q <= e_q.regwrite;
      m_mem_op_q   <= e_q.mem_op;
      m_rd_q       <= e_rd_q;
      w_valid_q    <= m_valid_q;
      w_regwrite_q <= m_regwrite_q;
      w_rd_q       <= m_rd_q;
      if (act == ACT_ADVANCE) begin
        e_q.valid    <= d_valid;
        e_q.regwrite <= d_regwrite;
        e_q.is_load  <= d_is_load;
        e_q.mem_op   <= d_mem_op;
        e_rs1_q      <= d_rs1;
        e_rs2_q      <= d_rs2;
        e_rd_q       <= d_rd;
      end else begin
        e_q     <= '0;
        e_rs1_q <= '0;
        e_rs2_q <= '0;
        e_rd_q  <= '0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_f),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_d),
    .count (flush_cnt)
  );

endmodule
